// File: rtl/nios2_ocimem_pkg.sv
// Shared constants for the OCI debug-RAM sequencer: FSM encodings,
// jdo field positions and the default RAM address width.
package nios2_ocimem_pkg;

  localparam int OCIMEM_ADDR_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_JRD  = 2'd1;
  localparam logic [1:0] ST_CRD  = 2'd2;

  localparam int JDO_CLR_ERR = 36;
  localparam int JDO_RD      = 35;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_ADDR_HI = 33;
  localparam int JDO_ADDR_LO = 26;
  localparam int JDO_DATA_LO = 3;

endpackage

// File: rtl/nios2_ocimem_rr_arb2.sv
// Two-requester round-robin arbiter (CPU vs JTAG) for the single-port OCI RAM.
// On contention the requester that did not win last time is granted.
module nios2_ocimem_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_jtag,
  output logic gnt_cpu,
  output logic gnt_jtag
);

  logic last_jtag_q;

  always_comb begin
    gnt_cpu  = req_cpu;
    gnt_jtag = req_jtag;
    if (req_cpu && req_jtag) begin
      gnt_cpu  = last_jtag_q;
      gnt_jtag = !last_jtag_q;
    end
  end

  // Resetting to "JTAG won last" makes the CPU the first contention winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_jtag_q <= 1'b1;
    end else if (gnt_cpu || gnt_jtag) begin
      last_jtag_q <= gnt_jtag;
    end
  end

endmodule

// File: rtl/nios2_ocimem_sequencer.sv
// Turns JTAG debug-slave strobes into OCI RAM accesses, sharing the RAM with
// the CPU debug slave, and reports read data and status back to the TCK side.
module nios2_ocimem_sequencer
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = OCIMEM_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  logic [ADDR_W-1:0] addr_q;
  logic              pend_q, pend_wr_q, pend_inc_q;
  logic [DATA_W-1:0] pend_wdata_q, mon_dreg_q;
  logic              mon_err_q;
  logic [1:0]        state_q, state_d;
  logic              busy, multi_strobe, err_clr, drop;
  logic              accept_a, accept_b, accept_n, queue_op;
  logic              gnt_cpu, gnt_jtag;
  logic              unused_jdo;

  assign unused_jdo   = ^{jdo[37], jdo[2:0]};
  assign busy         = pend_q || (state_q == ST_JRD);
  assign multi_strobe = (take_action_ocimem_a && take_action_ocimem_b)
                     || (take_action_ocimem_a && take_no_action_ocimem_a)
                     || (take_action_ocimem_b && take_no_action_ocimem_a);
  assign err_clr      = take_action_ocimem_a && jdo[JDO_CLR_ERR];

  // Only the highest-priority strobe is considered; anything it cannot do is an error.
  always_comb begin
    accept_a = 1'b0;
    accept_b = 1'b0;
    accept_n = 1'b0;
    drop     = 1'b0;
    if (take_action_ocimem_b) begin
      if (busy || !debugack) drop = 1'b1;
      else                   accept_b = 1'b1;
    end else if (take_action_ocimem_a) begin
      if (busy) drop = 1'b1;
      else      accept_a = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      if (busy) drop = 1'b1;
      else      accept_n = 1'b1;
    end
  end

  assign queue_op = accept_b || accept_n || (accept_a && jdo[JDO_RD]);

  nios2_ocimem_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_cpu  (cpu_read || cpu_write),
    .req_jtag (pend_q),
    .gnt_cpu  (gnt_cpu),
    .gnt_jtag (gnt_jtag)
  );

  always_comb begin
    ram_addr  = addr_q;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_wdata = pend_wdata_q;
    state_d   = ST_IDLE;
    if (gnt_jtag) begin
      ram_rd  = !pend_wr_q;
      ram_wr  = pend_wr_q;
      state_d = pend_wr_q ? ST_IDLE : ST_JRD;
    end else if (gnt_cpu) begin
      ram_addr  = cpu_address;
      ram_wr    = cpu_write;
      ram_rd    = cpu_read && !cpu_write;
      ram_wdata = cpu_writedata;
      state_d   = (cpu_read && !cpu_write) ? ST_CRD : ST_IDLE;
    end
  end

  // A clear in the same cycle as a fresh error wipes the old error but still reports the new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_inc_q   <= 1'b0;
      pend_wdata_q <= '0;
      mon_dreg_q   <= '0;
      mon_err_q    <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      state_q   <= state_d;
      mon_err_q <= (mon_err_q && !err_clr) || drop || multi_strobe;
      if (accept_a) begin
        addr_q <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
      end else if (gnt_jtag && pend_inc_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (queue_op) begin
        pend_q       <= 1'b1;
        pend_wr_q    <= accept_b;
        pend_inc_q   <= !accept_a;
        pend_wdata_q <= DATA_W'(jdo[JDO_DATA_HI:JDO_DATA_LO]);
      end else if (gnt_jtag) begin
        pend_q <= 1'b0;
      end
      if (state_q == ST_JRD) begin
        mon_dreg_q <= ram_rdata;
      end
    end
  end

  assign cpu_waitrequest   = (cpu_read || cpu_write) && !gnt_cpu;
  assign cpu_readdata      = ram_rdata;
  assign cpu_readdatavalid = (state_q == ST_CRD);
  assign MonDReg           = mon_dreg_q;
  assign monitor_ready     = !busy;
  assign monitor_error     = mon_err_q;

endmodule

// File: tb/tb_nios2_ocimem_sequencer.sv
// Directed bench for nios2_ocimem_sequencer with a behavioural 1-cycle-latency RAM.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_nios2_ocimem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tna, debugack;
  logic        cpu_read, cpu_write;
  logic [7:0]  cpu_address;
  logic [31:0] cpu_writedata;
  logic        cpu_waitrequest, cpu_readdatavalid;
  logic [31:0] cpu_readdata;
  logic [7:0]  ram_addr;
  logic        ram_rd, ram_wr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  nios2_ocimem_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna),
    .debugack                (debugack),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_address             (cpu_address),
    .cpu_writedata           (cpu_writedata),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid),
    .ram_addr                (ram_addr),
    .ram_rd                  (ram_rd),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  function automatic logic [37:0] mk_a(input logic clr, input logic rd, input logic [7:0] a);
    logic [37:0] j = '0;
    j[36] = clr;
    j[35] = rd;
    j[33:26] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic idle_strobes();
    ta_a = 1'b0; ta_b = 1'b0; tna = 1'b0; jdo = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_strobes();
    debugack = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_writedata = '0;
    preload(8'h20, 32'hA5A5A5A5);
    preload(8'h00, 32'h11111111);
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h01, 32'h01010101);
    preload(8'h42, 32'h42424242);
    preload(8'h30, 32'h30303030);
    @(negedge clk); #1;
    compared++; if (MonDReg !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_mondreg: got %h expected 0", MonDReg); end
    compared++; if (monitor_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_ready: got %b expected 1", monitor_ready); end
    compared++; if (monitor_error !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_error: got %b expected 0", monitor_error); end
    compared++; if (cpu_readdatavalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_rdv: got %b expected 0", cpu_readdatavalid); end
    compared++; if ({ram_rd, ram_wr} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_ram_en: got %b expected 00", {ram_rd, ram_wr}); end
    compared++; if (cpu_waitrequest !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_wait: got %b expected 0", cpu_waitrequest); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Both requesters first collide one cycle after the strobe; the CPU must win that.
  task automatic test_first_grant();
    @(negedge clk); tna = 1'b1; #1;
    @(negedge clk); tna = 1'b0; cpu_read = 1'b1; cpu_address = 8'h20; #1;
    compared++; if (cpu_waitrequest !== 1'b0) begin mismatched++; $display("[TB] FAIL first_cpu_wait: got %b expected 0", cpu_waitrequest); end
    compared++; if (ram_addr !== 8'h20 || ram_rd !== 1'b1) begin mismatched++; $display("[TB] FAIL first_cpu_ram: got addr %h rd %b expected 20 1", ram_addr, ram_rd); end
    @(negedge clk); cpu_read = 1'b0; #1;
    compared++; if (ram_addr !== 8'h00 || ram_rd !== 1'b1) begin mismatched++; $display("[TB] FAIL first_jtag_ram: got addr %h rd %b expected 00 1", ram_addr, ram_rd); end
    compared++; if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'hA5A5A5A5) begin mismatched++; $display("[TB] FAIL first_cpu_data: got v %b d %h expected 1 a5a5a5a5", cpu_readdatavalid, cpu_readdata); end
    @(negedge clk); #1;
    compared++; if (monitor_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL first_ready_jrd: got %b expected 0", monitor_ready); end
    @(negedge clk); #1;
    compared++; if (MonDReg !== 32'h11111111 || monitor_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL first_mondreg: got %h rdy %b expected 11111111 1", MonDReg, monitor_ready); end
  endtask

  task automatic test_jtag_read();
    @(negedge clk); ta_a = 1'b1; jdo = mk_a(1'b0, 1'b1, 8'h10); #1;
    @(negedge clk); idle_strobes(); #1;
    compared++; if (monitor_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_ready_s1: got %b expected 0", monitor_ready); end
    compared++; if (ram_rd !== 1'b1 || ram_addr !== 8'h10) begin mismatched++; $display("[TB] FAIL rd_ram_s1: got rd %b addr %h expected 1 10", ram_rd, ram_addr); end
    @(negedge clk); #1;
    compared++; if (monitor_ready !== 1'b0 || MonDReg !== 32'h11111111) begin mismatched++; $display("[TB] FAIL rd_s2: got rdy %b mon %h expected 0 11111111", monitor_ready, MonDReg); end
    @(negedge clk); #1;
    compared++; if (MonDReg !== 32'hDEADBEEF || monitor_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_s3: got mon %h rdy %b expected deadbeef 1", MonDReg, monitor_ready); end
    @(negedge clk); tna = 1'b1; #1;
    @(negedge clk); tna = 1'b0; #1;
    compared++; if (ram_addr !== 8'h10 || ram_rd !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_no_inc: got addr %h rd %b expected 10 1", ram_addr, ram_rd); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_wrap();
    debugack = 1'b1;
    @(negedge clk); ta_a = 1'b1; jdo = mk_a(1'b0, 1'b0, 8'hFF); #1;
    @(negedge clk); idle_strobes(); #1;
    compared++; if (monitor_ready !== 1'b1 || ram_rd !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_addr_only: got rdy %b rd %b expected 1 0", monitor_ready, ram_rd); end
    ta_b = 1'b1; jdo = mk_b(32'h1); #1;
    @(negedge clk); idle_strobes(); #1;
    compared++; if (ram_wr !== 1'b1 || ram_addr !== 8'hFF || ram_wdata !== 32'h1) begin mismatched++; $display("[TB] FAIL wr1_ram: got wr %b addr %h data %h expected 1 ff 1", ram_wr, ram_addr, ram_wdata); end
    @(negedge clk); #1;
    compared++; if (monitor_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL wr1_ready_s2: got %b expected 1", monitor_ready); end
    ta_b = 1'b1; jdo = mk_b(32'h2); #1;
    @(negedge clk); idle_strobes(); #1;
    compared++; if (ram_wr !== 1'b1 || ram_addr !== 8'h00 || ram_wdata !== 32'h2) begin mismatched++; $display("[TB] FAIL wr2_wrap: got wr %b addr %h data %h expected 1 00 2", ram_wr, ram_addr, ram_wdata); end
    @(negedge clk); tna = 1'b1; #1;
    compared++; if (mem[8'hFF] !== 32'h1 || mem[8'h00] !== 32'h2) begin mismatched++; $display("[TB] FAIL wr_mem: got ff=%h 00=%h expected 1 2", mem[8'hFF], mem[8'h00]); end
    @(negedge clk); tna = 1'b0; #1;
    compared++; if (ram_addr !== 8'h01 || ram_rd !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_next_addr: got addr %h rd %b expected 01 1", ram_addr, ram_rd); end
    repeat (2) @(negedge clk); #1;
    compared++; if (MonDReg !== 32'h01010101) begin mismatched++; $display("[TB] FAIL wr_readback: got %h expected 01010101", MonDReg); end
  endtask

  task automatic test_error_clear();
    debugack = 1'b0;
    @(negedge clk); ta_b = 1'b1; jdo = mk_b(32'h99); #1;
    @(negedge clk); idle_strobes(); #1;
    compared++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL err_set: got err %b rdy %b expected 1 1", monitor_error, monitor_ready); end
    for (int i = 0; i < 3; i++) begin
      compared++; if (ram_wr !== 1'b0) begin mismatched++; $display("[TB] FAIL err_no_wr: got %b expected 0", ram_wr); end
      @(negedge clk); #1;
    end
    compared++; if (monitor_error !== 1'b1) begin mismatched++; $display("[TB] FAIL err_sticky: got %b expected 1", monitor_error); end
    debugack = 1'b1;
    ta_a = 1'b1; jdo = mk_a(1'b1, 1'b0, 8'h40); #1;
    @(negedge clk); idle_strobes(); #1;
    compared++; if (monitor_error !== 1'b0) begin mismatched++; $display("[TB] FAIL err_clear: got %b expected 0", monitor_error); end
  endtask

  // JTAG reads issued whenever the slot frees up, CPU reading every cycle.
  task automatic test_contention();
    logic [8:0] exp_wait = 9'b010010010;
    logic [7:0] jaddr = 8'h40;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 8'h20;
      tna = (i % 3 == 0);
      #1;
      compared++; if (cpu_waitrequest !== exp_wait[i]) begin mismatched++; $display("[TB] FAIL cont_wait_c%0d: got %b expected %b", i, cpu_waitrequest, exp_wait[i]); end
      if (exp_wait[i]) begin
        compared++; if (ram_addr !== jaddr) begin mismatched++; $display("[TB] FAIL cont_jaddr_c%0d: got %h expected %h", i, ram_addr, jaddr); end
        jaddr = jaddr + 8'd1;
      end
    end
    @(negedge clk); cpu_read = 1'b0; tna = 1'b0; #1;
    compared++; if (MonDReg !== 32'h42424242) begin mismatched++; $display("[TB] FAIL cont_mondreg: got %h expected 42424242", MonDReg); end
  endtask

  task automatic test_drop();
    @(negedge clk); ta_a = 1'b1; jdo = mk_a(1'b0, 1'b1, 8'h10); #1;
    @(negedge clk); idle_strobes(); tna = 1'b1; #1;
    compared++; if (ram_addr !== 8'h10 || ram_rd !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_first_grant: got addr %h rd %b expected 10 1", ram_addr, ram_rd); end
    @(negedge clk); tna = 1'b0; #1;
    compared++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_err: got err %b rdy %b expected 1 0", monitor_error, monitor_ready); end
    @(negedge clk); #1;
    compared++; if (MonDReg !== 32'hDEADBEEF || monitor_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_first_done: got mon %h rdy %b expected deadbeef 1", MonDReg, monitor_ready); end
    tna = 1'b1; #1;
    @(negedge clk); tna = 1'b0; #1;
    compared++; if (ram_addr !== 8'h10) begin mismatched++; $display("[TB] FAIL drop_no_inc: got %h expected 10", ram_addr); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    @(negedge clk); ta_a = 1'b1; jdo = mk_a(1'b1, 1'b0, 8'h00); #1;
    @(negedge clk); idle_strobes(); #1;
    compared++; if (monitor_error !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_pre_clear: got %b expected 0", monitor_error); end
    ta_a = 1'b1; tna = 1'b1; jdo = mk_a(1'b0, 1'b1, 8'h30); #1;
    @(negedge clk); idle_strobes(); #1;
    compared++; if (monitor_error !== 1'b1 || ram_addr !== 8'h30 || ram_rd !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_winner: got err %b addr %h rd %b expected 1 30 1", monitor_error, ram_addr, ram_rd); end
    @(negedge clk); #1;
    compared++; if (monitor_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_single_op: got %b expected 0", monitor_ready); end
    @(negedge clk); #1;
    compared++; if (MonDReg !== 32'h30303030 || monitor_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_data: got mon %h rdy %b expected 30303030 1", MonDReg, monitor_ready); end
  endtask

  task automatic test_reset_mid_jrd();
    @(negedge clk); ta_a = 1'b1; jdo = mk_a(1'b0, 1'b1, 8'h10); #1;
    @(negedge clk); idle_strobes(); #1;
    @(negedge clk); reset = 1'b1; #1;
    compared++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst: got mon %h rdy %b err %b expected 0 1 0", MonDReg, monitor_ready, monitor_error); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      compared++; if (cpu_readdatavalid !== 1'b0 || MonDReg !== 32'h0 || monitor_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_rst_after_c%0d: got rdv %b mon %h rdy %b expected 0 0 1", i, cpu_readdatavalid, MonDReg, monitor_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_jtag_read();
    test_write_wrap();
    test_error_clear();
    test_contention();
    test_drop();
    test_simultaneous();
    test_reset_mid_jrd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_sequencer.md
# nios2_ocimem_sequencer

Sequences JTAG debug commands from the debug-slave sysclk strobes (`jdo`, `take_action_ocimem_*`) into single-port OCI debug-RAM accesses, sharing that RAM with the CPU-side debug Avalon slave through a two-way round-robin arbiter. Returns JTAG read data in `MonDReg`, plus `monitor_ready` and `monitor_error` status, back to the debug-slave TCK logic. Sits between the debug-slave wrapper and the OCI RAM, entirely in the `clk` domain.

## Interface
- Parameter `ADDR_W`, default 8: OCI RAM word-address width.
- Parameter `DATA_W`, default 32: RAM data width. Fixed to 32 by the `jdo` layout.
- Clocking: one clock. Reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous reset, active-high.
- `jdo` in 38: JTAG data word, valid in a strobe cycle.
- `take_action_ocimem_a` in 1: load address; optional read and error clear.
- `take_action_ocimem_b` in 1: write `jdo[34:3]` at the current address, then post-increment.
- `take_no_action_ocimem_a` in 1: read at the current address, then post-increment.
- `debugack` in 1: CPU is in debug mode; JTAG writes are legal only when this is 1.
- `cpu_read`, `cpu_write` in 1: CPU debug-slave request.
- `cpu_address` in ADDR_W: CPU request address.
- `cpu_writedata` in 32: CPU write data.
- `cpu_waitrequest` out 1: CPU request not granted this cycle.
- `cpu_readdata` out 32: CPU read data.
- `cpu_readdatavalid` out 1: `cpu_readdata` is valid.
- `ram_addr` out ADDR_W: RAM address.
- `ram_rd` out 1: RAM read enable.
- `ram_wr` out 1: RAM write enable.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid 1 cycle after `ram_rd`.
- `MonDReg` out 32: last JTAG read data.
- `monitor_ready` out 1: no JTAG operation pending or in flight.
- `monitor_error` out 1: sticky JTAG command error.

## Operation
- `jdo` decode for `ocimem_a`:
  - `addr <= jdo[33:26]`.
  - `jdo[35]=1`: queue a read at the new address, with no increment.
  - `jdo[36]=1`: clear `monitor_error`.
- Other commands:
  - `ocimem_b` queues a write.
  - `no_action_ocimem_a` queues a read.
  - Both post-increment `addr` when their RAM cycle is granted.
- Address increments wrap: 8'hFF → 8'h00.
- JTAG pending slot is one deep.
  - A strobe while the slot is pending or in flight is dropped and sets `monitor_error`.
  - The `jdo[36]` clear on a dropped `ocimem_a` still applies.
- Simultaneous strobes: priority is b > a > no_action. Only the winner is accepted; `monitor_error` is set.
- `ocimem_b` with `debugack=0` is dropped and sets `monitor_error`.
- Arbiter:
  - Requesters are JTAG-pending and CPU (`cpu_read|cpu_write`).
  - Lone requester wins.
  - When both request, the requester not granted last wins. After reset the CPU is favoured first.
- FSM states:
  - IDLE: grant per arbiter. JTAG read → JRD, JTAG write → IDLE, CPU read → CRD, CPU write → IDLE. All RAM ops issue in the grant cycle.
  - JRD: capture `ram_rdata` into `MonDReg`, clear the in-flight flag, → IDLE. Arbitration can grant CPU in this cycle.
  - CRD: `cpu_readdatavalid=1`, `cpu_readdata=ram_rdata`. New grants are allowed in the same cycle.

## Timing
- CPU is granted at cycle T:
  - `cpu_waitrequest=0` at T (combinational); `ram_*` driven at T.
  - Read data is valid at T+1.
  - Otherwise `cpu_waitrequest = cpu_read|cpu_write`.
- JTAG strobe at cycle S:
  - Pending from S+1; `monitor_ready` falls at S+1.
  - Earliest grant is S+1.
  - Read data appears in `MonDReg` at S+3.
  - `monitor_ready` rises at S+3 for reads and S+2 for writes.
- Reset values:
  - `MonDReg=0`, `monitor_ready=1`, `monitor_error=0`, `addr=0`.
  - `cpu_readdatavalid=0`, `ram_rd=0`, `ram_wr=0`, `cpu_waitrequest` follows the request.
- Reset mid-operation: in-flight read is discarded, and no `readdatavalid` or `MonDReg` update follows.

## Structure
- `nios2_ocimem_pkg`:
  - FSM state enum.
  - `jdo` bit-position constants: `JDO_CLR_ERR=36`, `JDO_RD=35`, `JDO_ADDR_HI=33`, `JDO_ADDR_LO=26`, `JDO_DATA_HI=34`, `JDO_DATA_LO=3`.
  - `ADDR_W` default.
- Sub-module `nios2_ocimem_rr_arb2`: 2-requester round-robin with a last-grant register.

## Test plan
- `ocimem_a` with `jdo[33:26]=8'h10`, `jdo[35]=1`; RAM[0x10]=32'hDEADBEEF → `MonDReg=32'hDEADBEEF` at S+3, `monitor_ready` low for S+1..S+2, `addr` stays 0x10.
- `debugack=1`: `ocimem_a` addr 0xFF, then two `ocimem_b` writes 32'h1, 32'h2 → RAM[0xFF]=1, RAM[0x00]=2, `addr=0x01`.
- `ocimem_b` with `debugack=0` → no `ram_wr`, `monitor_error=1`; then `ocimem_a` with `jdo[36]=1` → `monitor_error=0`.
- CPU read and JTAG read contend continuously → grants alternate CPU, JTAG, CPU…; `cpu_waitrequest` high only on JTAG cycles.
- Second strobe at S+1 while the first is pending → dropped, `monitor_error=1`, the first completes normally.
- Assert `reset` during JRD → `MonDReg=0`, `monitor_ready=1`, no `cpu_readdatavalid` afterward.
